// File: rtl/viterbi_frame_scheduler.sv
// Frame scheduler in front of a fixed-latency Viterbi decoder: queues 16-bit coded frames and launches them one at a time.
// Latency: launch 2 cycles after a push into an idle block; decoded byte valid DEC_LATENCY+1 cycles after the launch.
// Backpressure: s_ready drops when the frame FIFO is full; m_ready low holds the decoded byte and stalls further launches.
// Optional feature: define VITERBI_SCHED_STATS_EN to enable the completed-frame counter on frame_count.

// Generic synchronous FIFO with a combinational head read and wrap-around pointers.
module sched_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; push and pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

module viterbi_frame_scheduler #(
    parameter int DEPTH       = 4,
    parameter int DEC_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic [15:0] dec_data_in,
    output logic        dec_launch,
    input  logic [7:0]  dec_data_out,
    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic        m_ready,
    output logic        busy,
    output logic [7:0]  frame_count
);
    // Counter only has to hold DEC_LATENCY-1.
    localparam int CW = (DEC_LATENCY > 1) ? $clog2(DEC_LATENCY) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] lat_cnt;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   fifo_head;

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;
    // Only one frame may be inside the decoder, so the head is taken only from IDLE.
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty;

    sched_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_frame_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (s_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Launch / wait / hold sequencing; dec_data_in is held from launch until the byte is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            dec_data_in <= '0;
            dec_launch  <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        dec_data_in <= fifo_head;
                        dec_launch  <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    dec_launch <= 1'b0;
                    lat_cnt    <= CW'(DEC_LATENCY - 1);
                    state      <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        m_data  <= dec_data_out;
                        m_valid <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef VITERBI_SCHED_STATS_EN
    logic [7:0] frame_cnt_q;

    // Count accepted decoded bytes; wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (m_valid && m_ready) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_viterbi_frame_scheduler.sv
// Scoreboard bench for viterbi_frame_scheduler: a queue-level model tracks accepted frames and expected decoded bytes.
// The bench plays the decoder, driving a known byte only in the cycle the scheduler must sample it.
// Honours VITERBI_SCHED_STATS_EN for the expected frame_count.
module tb_viterbi_frame_scheduler;
    localparam int DEPTH = 4;
    localparam int DL    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [15:0] dec_data_in;
    logic        dec_launch;
    logic [7:0]  dec_data_out;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        busy;
    logic [7:0]  frame_count;

    viterbi_frame_scheduler #(
        .DEPTH       (DEPTH),
        .DEC_LATENCY (DL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .dec_data_in  (dec_data_in),
        .dec_launch   (dec_launch),
        .dec_data_out (dec_data_out),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .busy         (busy),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         at;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] frame_q[$];
    exp_t        exp_q[$];
    bit          inflight = 0;
    logic [15:0] cur_frame = '0;
    int          target = -1;
    logic [7:0]  target_byte = '0;
    int          hs_cnt = 0;
    int          launches = 0;
    int          last_launch_cyc = -100;
    logic        prev_mv = 1'b0;
    logic [7:0]  prev_md = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event with no expected entry (cycle %0d)", name, cyc);
    endtask

    function automatic logic [7:0] exp_fc(input int n);
`ifdef VITERBI_SCHED_STATS_EN
        return n[7:0];
`else
        return 8'd0;
`endif
    endfunction

    // Decoder stand-in: noise every cycle except the sampling cycle of the frame in flight.
    initial begin
        dec_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (target >= 0 && cyc == target) begin
                dec_data_out = target_byte;
                exp_q.push_back('{b: target_byte, at: cyc + 1});
                target = -1;
            end else begin
                dec_data_out = 8'($urandom);
            end
        end
    end

    // Monitor and scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            frame_q.delete();
            exp_q.delete();
            inflight = 0;
            target   = -1;
            hs_cnt   = 0;
            prev_mv  = 1'b0;
        end else begin
            if (dec_launch) begin
                launches++;
                last_launch_cyc = cyc;
                chk("one_in_flight", 32'(inflight), 32'd0);
                if (frame_q.size() == 0) begin
                    miss("launch_without_frame");
                end else begin
                    cur_frame = frame_q.pop_front();
                    chk("launch_frame", 32'(dec_data_in), 32'(cur_frame));
                end
                inflight    = 1;
                target      = cyc + DL;
                target_byte = 8'($urandom);
            end else if (inflight) begin
                chk("dec_data_in_stable", 32'(dec_data_in), 32'(cur_frame));
            end

            chk("s_ready", 32'(s_ready), 32'(frame_q.size() < DEPTH));
            chk("busy", 32'(busy), 32'(inflight || frame_q.size() > 0));

            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("m_valid_rise", {30'd0, m_valid, !prev_mv}, 32'd3);
                chk("m_data", 32'(m_data), 32'(e.b));
            end else if (m_valid && !prev_mv) begin
                miss("unexpected_m_valid");
            end else if (m_valid) begin
                chk("m_data_hold", 32'(m_data), 32'(prev_md));
            end

            if (m_valid && m_ready) begin
                chk("frame_count", 32'(frame_count), 32'(exp_fc(hs_cnt)));
                hs_cnt++;
                inflight = 0;
            end

            if (s_valid && s_ready) frame_q.push_back(s_data);
            prev_mv = m_valid;
            prev_md = m_data;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_dec_data_in"}, 32'(dec_data_in), 32'd0);
        chk({tag, "_dec_launch"}, 32'(dec_launch), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) step();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Offer one frame per cycle for n cycles; returns how many were accepted.
    task automatic offer(input int n, output int acc);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 16'($urandom);
            if (s_ready) acc++;
            step();
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int acc;
        int l0;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("por");
        step();
        rst = 1'b0;
        step();

        // Single frame from idle: launch two cycles after the push.
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 16'h3A5C; p = cyc; l0 = launches;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 20 && launches == l0; i++) step();
        chk("first_launch_cycle", 32'(last_launch_cyc), 32'(p + 2));
        wait_idle("single");

        // Fill with the output blocked: one in the decoder, DEPTH queued, the rest refused.
        m_ready = 1'b0;
        offer(DEPTH + 2, acc);
        chk("fill_accepted", 32'(acc), 32'(DEPTH + 1));
        chk("fill_s_ready", 32'(s_ready), 32'd0);
        l0 = launches;
        repeat (DL + 25) step();
        chk("hold_m_valid", 32'(m_valid), 32'd1);
        chk("no_launch_in_hold", 32'(launches), 32'(l0));
        m_ready = 1'b1;
        wait_idle("fill_drain");

        // Pop and push in the same cycle with two frames queued.
        m_ready = 1'b0;
        offer(3, acc);
        for (int i = 0; i < 40 && !m_valid; i++) step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'hBEEF;
        step();
        s_valid = 1'b0;
        offer(3, acc);
        chk("occupancy_after_pushpop", 32'(acc), 32'd2);
        m_ready = 1'b1;
        wait_idle("pushpop_drain");

        // Randomised traffic; enough handshakes to wrap an 8-bit counter.
        for (int i = 0; i < 20000 && hs_cnt < 280; i++) begin
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = 16'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_idle("random_drain");
        chk("frame_count_final", 32'(frame_count), 32'(exp_fc(hs_cnt)));

        // Reset during WAIT with three frames queued.
        m_ready = 1'b0;
        offer(4, acc);
        step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid");
        step();
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        l0 = launches;
        repeat (DL + 20) step();
        chk("post_reset_no_launch", 32'(launches), 32'(l0));
        chk("post_reset_m_valid", 32'(m_valid), 32'd0);
        chk("post_reset_s_ready", 32'(s_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
